button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Conditions the four raw push-button pins before they reach the game core's btn[3:0] input.
//  - Synchronises each pin to clk.
//  - Debounces each pin on a millisecond timebase derived from ticks_per_milli.
//  - Emits clean levels, one-cycle press/release pulses, and a one-hot key decode.
//  Sits directly upstream of the game core; btn_level drives its btn input unchanged.
// PARAMETERS
//  NUM_BTN      4   number of buttons (key_index is only defined for NUM_BTN=4)
//  DEBOUNCE_MS  10  ms a new level must persist before it is accepted; legal 1..31
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  ticks_per_milli in 16 clk cycles per ms; 0 is treated as 1
//  btn_raw      in   4   raw button pins, active-high, asynchronous to clk
//  btn_level    out  4   debounced button levels -> game core btn
//  btn_press    out  4   one-cycle pulse on an accepted 0->1 change, per button
//  btn_release  out  4   one-cycle pulse on an accepted 1->0 change, per button
//  key_valid    out  1   exactly one btn_level bit is set (combinational from btn_level)
//  key_index    out  2   index of the set bit when key_valid; 0 otherwise
//  key_multi    out  1   two or more btn_level bits are set
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//  - All flops clear immediately: synchronisers, tick counter, per-button FSMs, ms counts.
//  - All outputs read 0; key_index=0.
//  - Reset mid-debounce discards the pending change.
//  - A button still held when reset releases is re-debounced from scratch and produces a press.
//  Synchroniser
//  - 2-FF chain per bit; sync = second stage. Adds 2 cycles of latency.
//  Millisecond timebase
//  - 16-bit tick_cnt; ms_tick is high for one cycle when tick_cnt >= tpm-1, and tick_cnt then wraps to 0.
//    Otherwise tick_cnt increments. tpm = max(ticks_per_milli, 1).
//  - Using >= means a mid-count decrease of ticks_per_milli wraps on the next cycle; it never rolls over 65535.
//  - tpm=1 gives ms_tick on every cycle.
//  Per-button FSM (independent instance per bit; 5-bit ms_cnt)
//  - STABLE: if sync != btn_level -> PENDING, ms_cnt<=0. Any ms_tick in the entry cycle is ignored.
//  - PENDING, sync == btn_level: bounce rejected -> STABLE; no pulse; ms_cnt<=0.
//  - PENDING, ms_tick and ms_cnt == DEBOUNCE_MS-1: btn_level<=sync; one-cycle btn_press (new level 1)
//    or btn_release (new level 0), registered and coincident with the btn_level change; -> STABLE.
//  - PENDING, other ms_tick: ms_cnt<=ms_cnt+1.
//  - Bounce rejection has priority over commit in the same cycle.
//  - Accepted latency after a clean raw edge: 3+1+(DEBOUNCE_MS-1)*tpm to 3+DEBOUNCE_MS*tpm cycles.
//  - press/release are never both high for one bit in one cycle. Multiple bits may pulse in the same cycle.
//  Key decode (combinational from btn_level, zero latency)
//  - 0001->0, 0010->1, 0100->2, 1000->3 with key_valid=1.
//  - 0000: key_valid=0, key_multi=0.
//  - Two or more bits set: key_valid=0, key_multi=1, key_index=0.
// TESTING (ticks_per_milli=4, DEBOUNCE_MS=3 unless stated)
//  1 Reset: hold rst_n=0 with btn_raw=4'hF -> all outputs 0.
//    Release reset, keep pins high -> btn_press=4'hF for one cycle, 12..15 cycles after rst_n rises.
//  2 Clean press: btn_raw[2] 0->1 and held -> btn_press=4'b0100 pulses once, 12..15 cycles after the edge.
//    btn_level=4'b0100, key_valid=1, key_index=2.
//  3 Bounce reject: btn_raw[0] high for 6 cycles then low, repeated 3 times -> no btn_press.
//    btn_level stays 0 throughout.
//  4 Release and multi-key: hold btn 1 and btn 3 -> btn_level=4'b1010, key_multi=1, key_valid=0.
//    Drop btn 1 -> btn_release=4'b0010 once; then key_valid=1, key_index=3.
//  5 Timebase edges:
//    - ticks_per_milli=0 -> press 4..6 cycles after the raw edge.
//    - Change ticks_per_milli 1000->2 while tick_cnt=500 -> ms_tick fires on the next cycle.
//  6 Reset mid-debounce: assert rst_n=0 for 1 cycle halfway through PENDING -> outputs 0 immediately.
//    A held pin produces a press a full debounce period after reset release.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button conditioning bus: raw pins and timebase in, debounced levels, edge pulses
// and one-hot key decode out.
interface button_debouncer_if #(
    parameter int NUM_BTN = 4
);
    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [15:0]        ticks_per_milli;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               key_valid;
    logic [IDX_W-1:0]   key_index;
    logic               key_multi;

    modport master (
        output ticks_per_milli, btn_raw,
        input  btn_level, btn_press, btn_release, key_valid, key_index, key_multi
    );

    modport slave (
        input  ticks_per_milli, btn_raw,
        output btn_level, btn_press, btn_release, key_valid, key_index, key_multi
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF sync, shared millisecond timebase, one debounce FSM
// per pin, and a combinational one-hot key decode of the accepted levels.
module button_debouncer_lane #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    input  logic ms_tick_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o
);
    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       rel_q, rel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            // A tick landing in the entry cycle is deliberately not counted.
            ST_STABLE: begin
                if (sync_i != level_q) begin
                    state_d = ST_PENDING;
                    cnt_d   = '0;
                end
            end
            ST_PENDING: begin
                if (sync_i == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (ms_tick_i) begin
                    if (cnt_q == 5'(DEBOUNCE_MS - 1)) begin
                        level_d = sync_i;
                        press_d = sync_i;
                        rel_d   = ~sync_i;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;
endmodule

module button_debouncer #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debouncer_if.slave  bus
);
    localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [15:0]        tick_cnt_q, tick_cnt_d;
    logic [15:0]        tpm;
    logic               ms_tick;
    logic [NUM_BTN-1:0] level, press, rel;
    logic [7:0]         ones;
    logic [IDX_W-1:0]   idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // >= (not ==) so a lowered ticks_per_milli wraps at once instead of running to 65535.
    always_comb begin
        sync1_d    = bus.btn_raw;
        sync2_d    = sync1_q;
        tpm        = (bus.ticks_per_milli == 16'd0) ? 16'd1 : bus.ticks_per_milli;
        ms_tick    = (tick_cnt_q >= tpm - 16'd1);
        tick_cnt_d = ms_tick ? 16'd0 : tick_cnt_q + 16'd1;
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
        button_debouncer_lane #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .sync_i    (sync2_q[g]),
            .ms_tick_i (ms_tick),
            .level_o   (level[g]),
            .press_o   (press[g]),
            .rel_o     (rel[g])
        );
    end

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (level[i]) begin
                ones = ones + 8'd1;
                idx  = IDX_W'(i);
            end
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.key_valid   = (ones == 8'd1);
    assign bus.key_multi   = (ones > 8'd1);
    assign bus.key_index   = (ones == 8'd1) ? idx : '0;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (ticks_per_milli=4, DEBOUNCE_MS=3) with a
// cycle-level reference model compared on every falling edge.
module tb_button_debouncer;
    localparam int NB = 4;
    localparam int D  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    button_debouncer_if #(.NUM_BTN(NB)) bif ();

    button_debouncer #(.NUM_BTN(NB), .DEBOUNCE_MS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a pin's seen value lags raw by two clocks; a new value is accepted once it
    // has disagreed with the accepted level for D timebase ticks, not counting the first cycle.
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    int            m_age [NB];
    int            m_tc;

    initial begin : model
        int  tpm;
        bit  tick;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0; m_tc = 0;
                for (int b = 0; b < NB; b++) m_age[b] = -1;
            end else begin
                tpm  = (bif.ticks_per_milli == 0) ? 1 : int'(bif.ticks_per_milli);
                tick = (m_tc >= tpm - 1);
                m_press = '0;
                m_rel   = '0;
                for (int b = 0; b < NB; b++) begin
                    if (m_s2[b] == m_lvl[b]) m_age[b] = -1;
                    else if (m_age[b] < 0) m_age[b] = 0;
                    else if (tick) begin
                        m_age[b]++;
                        if (m_age[b] == D) begin
                            m_lvl[b]   = m_s2[b];
                            m_press[b] = m_s2[b];
                            m_rel[b]   = ~m_s2[b];
                            m_age[b]   = -1;
                        end
                    end
                end
                m_tc = tick ? 0 : m_tc + 1;
                m_s2 = m_s1;
                m_s1 = bif.btn_raw;
            end
        end
    end

    initial begin : compare
        logic [31:0] act, exp;
        int          n;
        forever begin
            @(negedge clk);
            n   = $countones(m_lvl);
            exp = {m_lvl, m_press, m_rel, 1'(n == 1), (n == 1) ? 2'($clog2(m_lvl)) : 2'd0, 1'(n > 1)};
            act = {bif.btn_level, bif.btn_press, bif.btn_release, bif.key_valid, bif.key_index,
                   bif.key_multi};
            chk("model_cycle", act, exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Counts rising edges from the current drive point until the wanted pulse appears.
    task automatic wait_pulse(input string nm, input bit is_press, input logic [3:0] mask,
                              input int lo, input int hi);
        int  n;
        bit  seen;
        seen = 0;
        for (n = 1; n <= hi + 6; n++) begin
            @(negedge clk);
            if ((is_press ? bif.btn_press : bif.btn_release) == mask) begin
                seen = 1;
                break;
            end
        end
        chk({nm, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk({nm, "_latency_ok"}, 32'(n >= lo && n <= hi), 32'd1);
        #1;
    endtask

    task automatic chk_outs(input string nm, input logic [3:0] lvl, input bit v, input logic [1:0] ix,
                            input bit mu);
        chk({nm, "_level"}, 32'(bif.btn_level), 32'(lvl));
        chk({nm, "_valid"}, 32'(bif.key_valid), 32'(v));
        chk({nm, "_index"}, 32'(bif.key_index), 32'(ix));
        chk({nm, "_multi"}, 32'(bif.key_multi), 32'(mu));
    endtask

    initial begin
        bit any_press;
        bif.btn_raw = 4'hF;
        bif.ticks_per_milli = 16'd4;

        // 1: reset with all pins held
        step(4);
        chk("rst_outs", {bif.btn_level, bif.btn_press, bif.btn_release, bif.key_valid,
                         bif.key_index, bif.key_multi}, 32'd0);
        rst_n = 1'b1;
        wait_pulse("rst_press", 1'b1, 4'hF, 12, 15);
        chk_outs("rst_held", 4'hF, 1'b0, 2'd0, 1'b1);

        // 2: clean press on pin 2
        bif.btn_raw = 4'h0;
        step(20);
        bif.btn_raw = 4'b0100;
        wait_pulse("clean_press", 1'b1, 4'b0100, 12, 15);
        chk_outs("clean", 4'b0100, 1'b1, 2'd2, 1'b0);

        // 3: bounce rejection on pin 0
        bif.btn_raw = 4'h0;
        step(20);
        any_press = 0;
        for (int r = 0; r < 3; r++) begin
            for (int h = 0; h < 12; h++) begin
                bif.btn_raw = (h < 6) ? 4'b0001 : 4'b0000;
                step(1);
                if (bif.btn_press != 4'h0 || bif.btn_level != 4'h0) any_press = 1;
            end
        end
        step(15);
        chk("bounce_no_press", 32'(any_press), 32'd0);
        chk("bounce_level", 32'(bif.btn_level), 32'd0);

        // 4: two keys, then drop one
        bif.btn_raw = 4'b1010;
        step(20);
        chk_outs("multi", 4'b1010, 1'b0, 2'd0, 1'b1);
        bif.btn_raw = 4'b1000;
        wait_pulse("drop1", 1'b0, 4'b0010, 12, 15);
        chk_outs("single3", 4'b1000, 1'b1, 2'd3, 1'b0);

        // 5a: ticks_per_milli=0 behaves as 1
        bif.btn_raw = 4'h0;
        bif.ticks_per_milli = 16'd0;
        step(20);
        bif.btn_raw = 4'b0001;
        wait_pulse("tpm0_press", 1'b1, 4'b0001, 4, 6);

        // 5b: lowering the period mid-count wraps on the next edge
        rst_n = 1'b0;
        bif.btn_raw = 4'h0;
        bif.ticks_per_milli = 16'd1000;
        step(2);
        rst_n = 1'b1;
        repeat (500) @(negedge clk);
        chk("tick_cnt_500", 32'(dut.tick_cnt_q), 32'd500);
        chk("no_tick_at_500", 32'(dut.ms_tick), 32'd0);
        #1;
        bif.ticks_per_milli = 16'd2;
        #1;
        chk("tick_after_drop", 32'(dut.ms_tick), 32'd1);
        @(negedge clk);
        chk("tick_cnt_wrapped", 32'(dut.tick_cnt_q), 32'd0);
        #1;
        bif.ticks_per_milli = 16'd4;

        // 6: reset halfway through a pending change
        bif.btn_raw = 4'b0010;
        wait_pulse("pre6_press", 1'b1, 4'b0010, 12, 15);
        bif.btn_raw = 4'b0110;
        step(7);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {bif.btn_level, bif.btn_press, bif.btn_release, bif.key_valid,
                            bif.key_index, bif.key_multi}, 32'd0);
        step(1);
        rst_n = 1'b1;
        wait_pulse("midrst_press", 1'b1, 4'b0110, 12, 15);
        chk_outs("midrst_held", 4'b0110, 1'b0, 2'd0, 1'b1);

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
